// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 2
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first,
// with a single registered borrow; result and borrow-out are held until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 2
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             a0, b0, dbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        a0       = a_q[0];
        b0       = b_q[0];
        dbit     = a0 ^ b0 ^ borrow_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = bus.Bin;
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                borrow_d       = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
                // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                d_d            = d_q >> 1;
                d_d[WIDTH-1]   = dbit;
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                cnt_d          = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d  = d_d;
                    bout_d  = borrow_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy = (state_q == StShift);
    assign bus.done = (state_q == StDone);
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=2 and WIDTH=8,
// checked against plain-arithmetic subtraction and an adder-style cross-check.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst2;
    logic rst8;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] prev_diff [2];
    logic       prev_bout [2];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(2)) bus2 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.slave)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
        if (w8) begin
            bus8.start = st;
            bus8.A     = a;
            bus8.B     = b;
            bus8.Bin   = bin;
        end else begin
            bus2.start = st;
            bus2.A     = a[1:0];
            bus2.B     = b[1:0];
            bus2.Bin   = bin;
        end
    endtask

    task automatic sample(input bit w8, output logic bsy, output logic dn,
                          output logic [7:0] diff, output logic bo);
        if (w8) begin
            bsy  = bus8.busy;
            dn   = bus8.done;
            diff = bus8.Diff;
            bo   = bus8.Bout;
        end else begin
            bsy  = bus2.busy;
            dn   = bus2.done;
            diff = {6'b0, bus2.Diff};
            bo   = bus2.Bout;
        end
    endtask

    // One full operation; with ignore set, start is pulsed with junk on every busy/done cycle.
    task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input bit ignore);
        int unsigned w, mask, ia, ib, sum;
        logic [7:0]  exp_diff, got_diff, d;
        logic        exp_bout, got_bout, bsy, dn, bo;
        int          busy_n, done_n, done_at;
        w        = w8 ? 8 : 2;
        mask     = (1 << w) - 1;
        ia       = a & mask;
        ib       = b & mask;
        exp_diff = 8'((ia - ib - bin) & mask);
        exp_bout = (ia < ib + bin);
        busy_n   = 0;
        done_n   = 0;
        done_at  = -1;
        got_diff = '0;
        got_bout = 1'b0;

        @(negedge clk);
        drive(w8, 1'b1, a, b, bin);
        @(negedge clk);
        for (int c = 0; c <= int'(w) + 2; c++) begin
            sample(w8, bsy, dn, d, bo);
            if (bsy) busy_n++;
            if (dn) begin
                done_n++;
                done_at  = c;
                got_diff = d;
                got_bout = bo;
            end
            if (c < int'(w)) begin
                check("hold_diff", 32'(d), 32'(prev_diff[w8]));
                check("hold_bout", 32'(bo), 32'(prev_bout[w8]));
            end else begin
                check("diff", 32'(d), 32'(exp_diff));
                check("bout", 32'(bo), 32'(exp_bout));
            end
            if (ignore && c <= int'(w))
                drive(w8, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            else
                drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
        end
        check("busy_cycles", busy_n, w);
        check("done_pulses", done_n, 1);
        check("done_latency", done_at, w);
        sum = got_diff + ib + bin;
        check("adder_sum", sum & mask, ia);
        check("adder_cout", (sum >> w) & 1, 32'(got_bout));
        prev_diff[w8] = exp_diff;
        prev_bout[w8] = exp_bout;
    endtask

    task automatic check_reset_state(input bit w8, input string tag);
        logic       bsy, dn, bo;
        logic [7:0] d;
        sample(w8, bsy, dn, d, bo);
        check({tag, "_busy"}, 32'(bsy), 0);
        check({tag, "_done"}, 32'(dn), 0);
        check({tag, "_diff"}, 32'(d), 0);
        check({tag, "_bout"}, 32'(bo), 0);
    endtask

    initial begin
        logic       bsy, dn, bo;
        logic [7:0] d;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        rst2 = 1'b1;
        rst8 = 1'b1;
        // Start held high during reset must be ignored.
        bus2.start = 1'b1;
        repeat (2) @(negedge clk);
        bus2.start = 1'b0;
        check_reset_state(1'b0, "rst2");
        check_reset_state(1'b1, "rst8");
        rst2 = 1'b0;
        rst8 = 1'b0;
        prev_diff[0] = '0;
        prev_diff[1] = '0;
        prev_bout[0] = 1'b0;
        prev_bout[1] = 1'b0;

        op(1'b0, 8'd3, 8'd1, 1'b0, 1'b0);
        op(1'b0, 8'd1, 8'd2, 1'b0, 1'b0);

        for (int i = 0; i < 32; i++)
            op(1'b0, 8'(i >> 3), 8'((i >> 1) & 3), 1'(i), 1'b0);

        op(1'b0, 8'd2, 8'd1, 1'b0, 1'b1);

        // Reset on the first busy cycle aborts without a done pulse.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd3, 8'd3, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        check("midrst_busy_before", 32'(bus2.busy), 1);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        check_reset_state(1'b0, "midrst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(1'b0, bsy, dn, d, bo);
            check("midrst_no_done", 32'(dn), 0);
        end
        prev_diff[0] = '0;
        prev_bout[0] = 1'b0;
        op(1'b0, 8'd2, 8'd0, 1'b1, 1'b0);

        op(1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
        op(1'b1, 8'h00, 8'hFF, 1'b1, 1'b0);
        op(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++)
            op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 10; i++)
            op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
